adc_rr_arbiter: RTL
===================

// Module: adc_rr_arbiter
// PURPOSE
//   Round-robin arbiter and sequencer for N_CH I2S capture channels (adc instances).
//   Per channel it:
//   - samples the valid flag (adc flag_out);
//   - latches the 32-bit word;
//   - returns a one-cycle ready/ack pulse (adc flag_in).
//   Granted words go out one at a time on a single valid/ready stream tagged with the channel index.
//   It flags frame completion once every enabled channel has delivered a word.
// PARAMETERS
//   N_CH   4    number of adc channels (>=2)
//   DW     32   data word width per channel
//   CW     $clog2(N_CH)  channel index width (derived, localparam)
// PORTS
//   sck        in   1         bit clock; shared with the adc instances; all logic on posedge
//   rst        in   1         reset; asynchronous, active-high
//   start      in   1         sticky enable; arbiter idle until sampled high once
//   ch_en      in   N_CH      per-channel enable mask; a disabled channel is never granted
//   adc_flag   in   N_CH      per-channel data-valid (adc flag_out)
//   adc_data   in   N_CH*DW   channel i word at [i*DW +: DW]
//   adc_ack    out  N_CH      per-channel ready pulse (adc flag_in), registered
//   out_valid  out  1         output word valid
//   out_ready  in   1         downstream ready
//   out_data   out  DW        granted word
//   out_ch     out  CW        index of the channel that produced out_data
//   frame_done out  1         one-cycle pulse: all enabled channels delivered since last pulse
// BEHAVIOUR
//   Reset (async, immediate):
//   - outputs: adc_ack=0, out_valid=0, out_data=0, out_ch=0, frame_done=0.
//   - internal state: started=0, ptr=0, sent mask=0, state=IDLE.
//   started:
//   - set on the first posedge with start=1; cleared only by rst.
//   - while 0, state stays IDLE.
//   FSM states (IDLE, ACK, SEND):
//   - IDLE: req = adc_flag & ch_en.
//     - If started and req!=0: grant g = first set bit of req searching ptr, ptr+1, ..., wrapping N_CH-1 -> 0.
//     - On that edge: out_data <= adc_data[g]; out_ch <= g; adc_ack[g] <= 1; ptr <= (g==N_CH-1) ? 0 : g+1.
//     - Next state ACK.
//   - ACK (exactly 1 cycle):
//     - adc_ack[g] is high during this cycle; the adc clears its flag on the closing edge.
//     - On that edge: adc_ack <= 0; out_valid <= 1; next state SEND.
//     - No arbitration in ACK, so the still-high flag of g is never re-granted.
//   - SEND:
//     - out_valid, out_data and out_ch are held stable until out_ready=1 at a posedge.
//     - On that edge: out_valid <= 0; next state IDLE.
//   Latency and throughput:
//   - req seen at edge k -> adc_ack high k..k+1 -> out_valid high from edge k+1.
//   - Peak rate 1 word per 3 sck cycles when out_ready is held at 1.
//   adc_ack is one-hot or zero at all times; high for exactly one cycle per grant.
//   Frame tracking:
//   - On the SEND->IDLE edge: sent <= sent | (1<<out_ch).
//   - If ((sent | (1<<out_ch)) & ch_en) == ch_en and ch_en != 0: frame_done <= 1 for one cycle, and sent <= 0.
//   - Bits of sent for disabled channels are ignored.
//   - ch_en == 0: no grants, no frame_done.
//   Boundary conditions:
//   - ch_en bit dropped while that channel is in ACK/SEND: the transfer completes normally.
//   - out_ready high in the same cycle out_valid rises: accepted on the following edge (SEND lasts at least 1 cycle).
//   - Simultaneous requests on all channels: served strictly in rotation starting at ptr; no channel is starved.
//   - rst mid-transfer: adc_ack drops immediately; the word in flight is discarded.
//     The adc instances share rst and clear their own flags.
//   - start low after being sampled high: no effect.
// TESTING
//   1 Reset/start:
//     - adc_flag=4'b1111, start=0 for 10 cycles -> adc_ack=0, out_valid=0.
//     - Assert start -> first grant is ch0.
//   2 Round-robin order:
//     - All flags high continuously; out_ready=1.
//     - out_ch sequence 0,1,2,3,0 at one word per 3 cycles.
//     - frame_done pulses the cycle after the ch3 word is accepted.
//   3 Handshake timing:
//     - ch2 flag high, adc_data[2]=32'hA5A5_5A00.
//     - adc_ack=4'b0100 for exactly 1 cycle.
//     - out_valid next edge with out_data=32'hA5A5_5A00, out_ch=2.
//     - Hold out_ready=0 for 5 cycles -> outputs stable; no new ack.
//   4 Enable mask:
//     - ch_en=4'b1010, all flags high.
//     - Only ch1, ch3 granted; ch0/ch2 adc_ack never high.
//     - frame_done after ch1 and ch3 have both been accepted.
//   5 Reset mid-operation:
//     - Assert rst during ACK -> adc_ack=0 and out_valid=0 immediately.
//     - After release plus start, arbitration restarts at ch0.
//   6 Pointer wrap:
//     - Only ch3 and ch0 valid, ptr=3 -> grant ch3 then ch0; ptr wraps to 1.

Source files
------------

// File: rtl/adc_rr_arbiter.sv
// Round-robin arbiter and sequencer for N_CH I2S capture channels: grants one channel
// word at a time onto a tagged valid/ready stream and flags completion of each frame.
//
// state | meaning
// IDLE  | idle until started; arbitrates adc_flag & ch_en from ptr and latches the word
// ACK   | one-cycle ack pulse to the granted adc (its flag is still high, no arbitration)
// SEND  | out_valid/out_data/out_ch held until out_ready is seen at a posedge
module adc_rr_arbiter #(
    parameter  int N_CH = 4,
    parameter  int DW   = 32,
    localparam int CW   = $clog2(N_CH)
) (
    input  logic               sck,
    input  logic               rst,
    input  logic               start,
    input  logic [N_CH-1:0]    ch_en,
    input  logic [N_CH-1:0]    adc_flag,
    input  logic [N_CH*DW-1:0] adc_data,
    output logic [N_CH-1:0]    adc_ack,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DW-1:0]      out_data,
    output logic [CW-1:0]      out_ch,
    output logic               frame_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK  = 2'd1,
        SEND = 2'd2
    } state_t;

    localparam logic [CW-1:0] LAST_CH = CW'(N_CH - 1);

    state_t          state;
    state_t          state_nxt;
    logic            started;
    logic [CW-1:0]   ptr;
    logic [CW-1:0]   ptr_nxt;
    logic [N_CH-1:0] sent;
    logic [N_CH-1:0] sent_nxt;
    logic [N_CH-1:0] sent_upd;
    logic [N_CH-1:0] ack_nxt;
    logic            valid_nxt;
    logic [DW-1:0]   data_nxt;
    logic [CW-1:0]   ch_nxt;
    logic            done_nxt;
    logic [N_CH-1:0] req;
    logic [CW-1:0]   grant;
    logic [DW-1:0]   words [N_CH];

    // First set bit of req searching start_ptr, start_ptr+1, ... with wrap to 0.
    function automatic logic [CW-1:0] rr_pick(input logic [N_CH-1:0] r,
                                              input logic [CW-1:0]   start_ptr);
        logic [CW-1:0] pick;
        logic          found;
        int            idx;
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            idx = (int'(start_ptr) + i) % N_CH;
            if (!found && r[idx]) begin
                found = 1'b1;
                pick  = idx[CW-1:0];
            end
        end
        return pick;
    endfunction

    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            words[i] = adc_data[i*DW +: DW];
        end
    end

    assign req   = adc_flag & ch_en;
    assign grant = rr_pick(req, ptr);

    always_comb begin
        sent_upd         = sent;
        sent_upd[out_ch] = 1'b1;
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        sent_nxt  = sent;
        ack_nxt   = '0;
        valid_nxt = out_valid;
        data_nxt  = out_data;
        ch_nxt    = out_ch;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (started && (req != '0)) begin
                    data_nxt       = words[grant];
                    ch_nxt         = grant;
                    ack_nxt[grant] = 1'b1;
                    ptr_nxt        = (grant == LAST_CH) ? '0 : grant + 1'b1;
                    state_nxt      = ACK;
                end
            end
            ACK: begin
                valid_nxt = 1'b1;
                state_nxt = SEND;
            end
            SEND: begin
                if (out_ready) begin
                    valid_nxt = 1'b0;
                    state_nxt = IDLE;
                    // sent bits of disabled channels are masked out of the completion test
                    if ((ch_en != '0) && ((sent_upd & ch_en) == ch_en)) begin
                        done_nxt = 1'b1;
                        sent_nxt = '0;
                    end else begin
                        sent_nxt = sent_upd;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sck or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            started    <= 1'b0;
            ptr        <= '0;
            sent       <= '0;
            adc_ack    <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_ch     <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            started    <= started | start;
            ptr        <= ptr_nxt;
            sent       <= sent_nxt;
            adc_ack    <= ack_nxt;
            out_valid  <= valid_nxt;
            out_data   <= data_nxt;
            out_ch     <= ch_nxt;
            frame_done <= done_nxt;
        end
    end

endmodule
